// File: rtl/text_mode_pkg.sv
// Shared types and constants for the attribute text-mode renderer.
// Latency constant, attribute bit positions and the power-on CGA palette.
package text_mode_pkg;

  localparam int LATENCY = 4;

  localparam int ATTR_CODE_LSB  = 0;
  localparam int ATTR_FG_LSB    = 8;
  localparam int ATTR_BG_LSB    = 12;
  localparam int ATTR_BLINK_BIT = 15;

  typedef logic [23:0] rgb_t;

  // Upper byte of a character word: {blink, bg[2:0], fg[3:0]}
  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  typedef struct packed {
    logic       va;
    logic       en;
    logic       in_area;
    logic [2:0] gcol;
  } side_t;

  function automatic rgb_t cga_rgb(input logic [3:0] idx);
    rgb_t c;
    case (idx)
      4'h0:    c = 24'h000000;
      4'h1:    c = 24'h0000AA;
      4'h2:    c = 24'h00AA00;
      4'h3:    c = 24'h00AAAA;
      4'h4:    c = 24'hAA0000;
      4'h5:    c = 24'hAA00AA;
      4'h6:    c = 24'hAA5500;
      4'h7:    c = 24'hAAAAAA;
      4'h8:    c = 24'h555555;
      4'h9:    c = 24'h5555FF;
      4'hA:    c = 24'h55FF55;
      4'hB:    c = 24'h55FFFF;
      4'hC:    c = 24'hFF5555;
      4'hD:    c = 24'hFF55FF;
      4'hE:    c = 24'hFFFF55;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_palette.sv
// 16-entry x 24-bit palette, reset to CGA colours, two async read ports.
// Latency: reads combinational, write lands at the clock edge; no backpressure.
// A read of the index being written in the same cycle returns the old entry.
module text_palette
  import text_mode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  rgb_t        wdata,
  input  logic [3:0]  raddr_a,
  output rgb_t        rdata_a,
  input  logic [3:0]  raddr_b,
  output rgb_t        rdata_b
);

  rgb_t mem_q [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= cga_rgb(4'(i));
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/wb_text_mode_attr.sv
// Attribute text-mode pixel renderer: char RAM -> font ROM -> palette -> RGB.
// Latency 4 cycles pixel-in to RGB-out; free-running pipeline, no backpressure.
// Optional hardware cursor underline via TEXT_CURSOR_EN.
module wb_text_mode_attr
  import text_mode_pkg::*;
#(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 26,
  parameter int          SCALE_LOG2 = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter int          ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [11:0]       pixel_x,
  input  logic [11:0]       pixel_y,
  input  logic              video_active,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] char_addr,
  input  logic [15:0]       char_data,
  output logic [10:0]       font_addr,
  input  logic [7:0]        font_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [23:0]       pal_data,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]        cursor_x,
  input  logic [4:0]        cursor_y,
`endif
  output logic [7:0]        text_r,
  output logic [7:0]        text_g,
  output logic [7:0]        text_b,
  output logic              text_valid
);

  localparam int SH   = 3 + SCALE_LOG2;
  localparam int CELL = 8 << SCALE_LOG2;

  logic [11:0] col0, row0;
  logic [2:0]  grow0;
  side_t       side0;

  assign col0      = pixel_x >> SH;
  assign row0      = pixel_y >> SH;
  assign grow0     = pixel_y[SCALE_LOG2+2:SCALE_LOG2];
  assign char_addr = ADDR_W'(32'(row0) * 32'(COLS) + 32'(col0));

  always_comb begin
    side0         = '0;
    side0.va      = video_active;
    side0.en      = enable;
    side0.in_area = (32'(pixel_x) < 32'(COLS * CELL)) && (32'(pixel_y) < 32'(ROWS * CELL));
    side0.gcol    = pixel_x[SCALE_LOG2+2:SCALE_LOG2];
  end

  side_t      side1_q, side2_q;
  logic [2:0] grow1_q;
  attr_t      attr2_q, attr3_q;
  logic       va3_q, en3_q, in3_q, bit3_q;
  logic [5:0] frame_q, frame_d;
  rgb_t       rgb_q, rgb_d;
  logic       valid_q;

  // Glyph row rides alongside the returned character code
  assign font_addr = {char_data[ATTR_CODE_LSB +: 8], grow1_q};
  assign frame_d   = frame_start ? frame_q + 6'd1 : frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side1_q <= '0;
      grow1_q <= '0;
      side2_q <= '0;
      attr2_q <= '0;
      attr3_q <= '0;
      va3_q   <= 1'b0;
      en3_q   <= 1'b0;
      in3_q   <= 1'b0;
      bit3_q  <= 1'b0;
      frame_q <= '0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      side1_q <= side0;
      grow1_q <= grow0;
      side2_q <= side1_q;
      attr2_q <= attr_t'(char_data[15:8]);
      attr3_q <= attr2_q;
      va3_q   <= side2_q.va;
      en3_q   <= side2_q.en;
      in3_q   <= side2_q.in_area;
      bit3_q  <= font_data[~side2_q.gcol];
      frame_q <= frame_d;
      rgb_q   <= rgb_d;
      valid_q <= va3_q;
    end
  end

  logic cur3;
`ifdef TEXT_CURSOR_EN
  logic cur1_q, cur2_q, cur3_q;
  logic cur0;

  assign cur0 = (col0 == 12'(cursor_x)) && (row0 == 12'(cursor_y)) && (grow0 == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur1_q <= 1'b0;
      cur2_q <= 1'b0;
      cur3_q <= 1'b0;
    end else begin
      cur1_q <= cur0;
      cur2_q <= cur1_q;
      cur3_q <= cur2_q;
    end
  end

  assign cur3 = cur3_q;
`else
  assign cur3 = 1'b0;
`endif

  rgb_t pal_fg, pal_bg;

  text_palette u_palette (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (pal_we),
    .waddr   (pal_addr),
    .wdata   (pal_data),
    .raddr_a (attr3_q.fg),
    .rdata_a (pal_fg),
    .raddr_b ({1'b0, attr3_q.bg}),
    .rdata_b (pal_bg)
  );

  logic phase, fg_on;
  assign phase = frame_q[5];
  // Blink hides the glyph in phase 1; the cursor underline shows in phase 0
  assign fg_on = (bit3_q & ~(attr3_q.blink & phase)) | (cur3 & ~phase);

  always_comb begin
    rgb_d = '0;
    if (va3_q && en3_q) begin
      if (!in3_q)     rgb_d = BORDER_RGB;
      else if (fg_on) rgb_d = pal_fg;
      else            rgb_d = pal_bg;
    end
  end

  assign text_r     = rgb_q[23:16];
  assign text_g     = rgb_q[15:8];
  assign text_b     = rgb_q[7:0];
  assign text_valid = valid_q;

endmodule

// File: tb/tb_wb_text_mode_attr.sv
// Directed self-checking bench for wb_text_mode_attr (default and COLS=40/scale 1 instances).
// Models a registered char RAM and font ROM holding a single 'A' glyph.
module tb_wb_text_mode_attr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] pixel_x, pixel_y;
  logic        video_active;
  logic        frame_start;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [7:0]  text_r, text_g, text_b;
  logic        text_valid;

  logic [11:0] p2x, p2y;
  logic [11:0] char_addr2;
  logic [10:0] font_addr2;
  logic [7:0]  r2, g2, b2;
  logic        valid2;

  logic [15:0] char_word;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  wb_text_mode_attr dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_active(video_active),
    .frame_start(frame_start), .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`ifdef TEXT_CURSOR_EN
    .cursor_x(cursor_x), .cursor_y(cursor_y),
`endif
    .text_r(text_r), .text_g(text_g), .text_b(text_b), .text_valid(text_valid)
  );

  wb_text_mode_attr #(.COLS(40), .SCALE_LOG2(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pixel_x(p2x), .pixel_y(p2y), .video_active(video_active),
    .frame_start(1'b0), .char_addr(char_addr2), .char_data(16'h0000),
    .font_addr(font_addr2), .font_data(8'h00),
    .pal_we(1'b0), .pal_addr(4'h0), .pal_data(24'h0),
`ifdef TEXT_CURSOR_EN
    .cursor_x(7'd0), .cursor_y(5'd0),
`endif
    .text_r(r2), .text_g(g2), .text_b(b2), .text_valid(valid2)
  );

  function automatic logic [7:0] font_rom(input logic [7:0] code, input logic [2:0] r);
    logic [7:0] g;
    g = 8'h00;
    if (code == 8'h41) begin
      case (r)
        3'd0: g = 8'h18;
        3'd1: g = 8'h3C;
        3'd2: g = 8'h66;
        3'd3: g = 8'h66;
        3'd4: g = 8'h7E;
        3'd5: g = 8'h66;
        3'd6: g = 8'h66;
        default: g = 8'h00;
      endcase
    end
    return g;
  endfunction

  always @(posedge clk) begin
    char_data <= char_word;
    font_data <= font_rom(font_addr[10:3], font_addr[2:0]);
  end

  task automatic px(input logic [11:0] x, input logic [11:0] y, input logic va,
                    output logic [23:0] rgb, output logic vld);
    pixel_x = x;
    pixel_y = y;
    video_active = va;
    repeat (4) @(posedge clk);
    #1;
    rgb = {text_r, text_g, text_b};
    vld = text_valid;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({text_r, text_g, text_b} !== 24'h0) begin
      failures++; $display("FAIL reset_rgb got=%h want=000000", {text_r, text_g, text_b});
    end
    checks++;
    if (text_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b want=0", text_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_glyph;
    logic [7:0]  row;
    logic [23:0] exp_rgb;
    int          k;
    for (int i = 0; i < 260; i++) begin
      if (i >= 4) begin
        k = i - 4;
        row = font_rom(8'h41, 3'((k / 16) >> 1));
        exp_rgb = row[~3'((k % 16) >> 1)] ? 24'hFFFFFF : 24'h0000AA;
        checks++;
        if ({text_r, text_g, text_b} !== exp_rgb || text_valid !== 1'b1) begin
          failures++;
          $display("FAIL glyph px(%0d,%0d) got=%h/%b want=%h/1", k % 16, k / 16,
                   {text_r, text_g, text_b}, text_valid, exp_rgb);
        end
      end
      if (i < 256) begin
        pixel_x = 12'(i % 16);
        pixel_y = 12'(i / 16);
        video_active = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_border;
    logic [23:0] rgb;
    logic        vld;
    px(12'd1280, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h000000 || vld !== 1'b1) begin
      failures++; $display("FAIL border_x1280 got=%h/%b want=000000/1", rgb, vld);
    end
    px(12'd1279, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA || vld !== 1'b1) begin
      failures++; $display("FAIL edge_x1279 got=%h/%b want=0000aa/1", rgb, vld);
    end
    px(12'd0, 12'd416, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h000000 || vld !== 1'b1) begin
      failures++; $display("FAIL border_y416 got=%h/%b want=000000/1", rgb, vld);
    end
    px(12'd0, 12'd415, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA || vld !== 1'b1) begin
      failures++; $display("FAIL edge_y415 got=%h/%b want=0000aa/1", rgb, vld);
    end
  endtask

  task automatic test_video_enable;
    logic [23:0] rgb;
    logic        vld;
    px(12'd6, 12'd0, 1'b0, rgb, vld);
    checks++;
    if (rgb !== 24'h0 || vld !== 1'b0) begin
      failures++; $display("FAIL video_inactive got=%h/%b want=000000/0", rgb, vld);
    end
    enable = 1'b0;
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0 || vld !== 1'b1) begin
      failures++; $display("FAIL enable_low got=%h/%b want=000000/1", rgb, vld);
    end
    enable = 1'b1;
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFFFFFF || vld !== 1'b1) begin
      failures++; $display("FAIL enable_restore got=%h/%b want=ffffff/1", rgb, vld);
    end
  endtask

  task automatic test_addr;
    pixel_x = 12'd32; pixel_y = 12'd16;
    p2x = 12'd8; p2y = 12'd8;
    #1;
    checks++;
    if (char_addr !== 12'd82) begin
      failures++; $display("FAIL addr_32_16 got=%0d want=82", char_addr);
    end
    checks++;
    if (char_addr2 !== 12'd41) begin
      failures++; $display("FAIL addr2_8_8 got=%0d want=41", char_addr2);
    end
    pixel_x = 12'd1279; pixel_y = 12'd415;
    p2x = 12'd319; p2y = 12'd0;
    #1;
    checks++;
    if (char_addr !== 12'd2079) begin
      failures++; $display("FAIL addr_last got=%0d want=2079", char_addr);
    end
    checks++;
    if (char_addr2 !== 12'd39) begin
      failures++; $display("FAIL addr2_319_0 got=%0d want=39", char_addr2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_blink;
    logic [23:0] rgb;
    logic        vld;
    char_word = 16'h9F41;
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++; $display("FAIL blink_phase0 got=%h want=ffffff", rgb);
    end
    pulses(31);
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++; $display("FAIL blink_31 got=%h want=ffffff", rgb);
    end
    pulses(1);
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA) begin
      failures++; $display("FAIL blink_32 got=%h want=0000aa", rgb);
    end
    pulses(32);
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++; $display("FAIL blink_64 got=%h want=ffffff", rgb);
    end
    char_word = 16'h1F41;
  endtask

  task automatic test_palette;
    logic [23:0] rgb;
    logic        vld;
    pixel_x = 12'd6; pixel_y = 12'd0; video_active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pal_we = 1'b1; pal_addr = 4'd15; pal_data = 24'hFF0000;
    @(posedge clk); #1;
    pal_we = 1'b0;
    checks++;
    if ({text_r, text_g, text_b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL pal_same_cycle got=%h want=ffffff", {text_r, text_g, text_b});
    end
    px(12'd6, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFF0000) begin
      failures++; $display("FAIL pal_written got=%h want=ff0000", rgb);
    end
    px(12'd0, 12'd0, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA) begin
      failures++; $display("FAIL pal_bg_kept got=%h want=0000aa", rgb);
    end
  endtask

  task automatic test_reset_mid;
    pixel_x = 12'd6; pixel_y = 12'd0; video_active = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({text_r, text_g, text_b} !== 24'h0 || text_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_out got=%h/%b want=000000/0", {text_r, text_g, text_b}, text_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (text_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_3cyc got=%b want=0", text_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({text_r, text_g, text_b} !== 24'hFFFFFF || text_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_4cyc got=%h/%b want=ffffff/1", {text_r, text_g, text_b}, text_valid);
    end
  endtask

  task automatic test_cursor;
    logic [23:0] rgb;
    logic        vld;
`ifdef TEXT_CURSOR_EN
    px(12'd32, 12'd30, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++; $display("FAIL cursor_32_30 got=%h want=ffffff", rgb);
    end
    px(12'd47, 12'd31, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++; $display("FAIL cursor_47_31 got=%h want=ffffff", rgb);
    end
    px(12'd32, 12'd28, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA) begin
      failures++; $display("FAIL cursor_row6 got=%h want=0000aa", rgb);
    end
    px(12'd48, 12'd30, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA) begin
      failures++; $display("FAIL cursor_nextcell got=%h want=0000aa", rgb);
    end
    pulses(32);
    px(12'd32, 12'd30, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA) begin
      failures++; $display("FAIL cursor_phase1 got=%h want=0000aa", rgb);
    end
    pulses(32);
`else
    px(12'd32, 12'd30, 1'b1, rgb, vld);
    checks++;
    if (rgb !== 24'h0000AA) begin
      failures++; $display("FAIL nocursor_32_30 got=%h want=0000aa", rgb);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b1;
    enable = 1'b1;
    pixel_x = '0; pixel_y = '0; video_active = 1'b0;
    p2x = '0; p2y = '0;
    frame_start = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    cursor_x = 7'd2; cursor_y = 5'd1;
    char_word = 16'h1F41;
    @(posedge clk); #1;
    test_reset;
    test_glyph;
    test_border;
    test_video_enable;
    test_addr;
    test_blink;
    test_cursor;
    test_palette;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
